// File: rtl/pulse_interval_monitor_if.sv
// pulse_interval_monitor_if: valid/ready interval word port with its saturation flag.
interface pulse_interval_monitor_if #(parameter int CNT_W = 16) ();
  logic             iv_valid;
  logic             iv_ready;
  logic [CNT_W-1:0] iv_data;
  logic             iv_sat;
  modport master (output iv_valid, iv_data, iv_sat, input iv_ready);
  modport slave (input iv_valid, iv_data, iv_sat, output iv_ready);
endinterface

// File: rtl/pulse_interval_monitor.sv
// pulse_interval_monitor: measures cycles between rising edges of pulse_in and keeps running statistics.
// Define PULSE_SYNC_EN to pass pulse_in through a 2-flop synchroniser before edge detection.
module pulse_interval_monitor #(
  parameter int CNT_W  = 16,
  parameter int PCNT_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pulse_in,
  input  logic                  clear,
  pulse_interval_monitor_if.master iv,
  output logic [PCNT_W-1:0]     pulse_count,
  output logic [CNT_W-1:0]      min_iv,
  output logic [CNT_W-1:0]      max_iv,
  output logic                  overrun
);
  typedef enum logic {IDLE, MEASURE} state_t;
  state_t state, state_nx;
  logic p, p_q, pe, meas_edge, take, load;
  logic [CNT_W-1:0] cnt;
`ifdef PULSE_SYNC_EN
  logic [1:0] sync;
  always_ff @(posedge clk) sync <= rst ? 2'b00 : {sync[0], pulse_in};
  assign p = sync[1];
`else
  assign p = pulse_in;
`endif
  // p_q keeps sampling through clear so a held-high line is not re-counted
  always_ff @(posedge clk) p_q <= rst ? 1'b0 : p;
  assign pe = p & ~p_q;
  always_ff @(posedge clk) state <= rst ? IDLE : state_nx;
  always_comb begin
    state_nx  = clear ? IDLE : (pe ? MEASURE : state);
    meas_edge = pe & (state == MEASURE);
    take      = iv.iv_valid & iv.iv_ready;
    load      = meas_edge & (~iv.iv_valid | iv.iv_ready);
  end
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt         <= '0;
      pulse_count <= '0;
      min_iv      <= '1;
      max_iv      <= '0;
      iv.iv_valid <= 1'b0;
      iv.iv_data  <= '0;
      iv.iv_sat   <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      if (pe) begin
        cnt         <= CNT_W'(1);
        pulse_count <= pulse_count + 1'b1;
      end else if (state == MEASURE && cnt != '1) begin
        cnt <= cnt + 1'b1;
      end
      if (meas_edge) begin
        if (cnt < min_iv) min_iv <= cnt;
        if (cnt > max_iv) max_iv <= cnt;
      end
      if (load) begin
        iv.iv_valid <= 1'b1;
        iv.iv_data  <= cnt;
        iv.iv_sat   <= &cnt;
      end else if (take) begin
        iv.iv_valid <= 1'b0;
      end
      if (meas_edge && !load) overrun <= 1'b1;
    end
  end
endmodule
